// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the ALU: accepts one op, pulses alu_ena, waits the settle time, holds the result.
// Optional sticky {carry, overflow} accumulator is built when ALU_SEQ_STICKY_FLAGS_EN is defined.
module alu_op_sequencer #(
  parameter int ALU_WAIT = 1,
  parameter int MUL_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  op_func,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_shamt,
  output logic [31:0] alu_inp1,
  output logic [31:0] alu_inp2,
  output logic [4:0]  alu_shAmt,
  output logic [5:0]  alu_func,
  output logic        alu_ena,
  input  logic [31:0] alu_res1,
  input  logic [31:0] alu_res2,
  input  logic        alu_carry,
  input  logic        alu_sign,
  input  logic        alu_ovf,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res1_q,
  output logic [31:0] res2_q,
  output logic [3:0]  flags_q,
  output logic        res_err
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  ,
  input  logic        sticky_clr,
  output logic [1:0]  sticky_q
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, FIRE, WAIT, DONE} state_t;

  localparam logic [3:0] ALU_LOAD = 4'(ALU_WAIT - 1);
  localparam logic [3:0] MUL_LOAD = 4'(MUL_WAIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       is_mul;
  logic       capture;

  // The func is taken from the latched ALU select so it cannot change mid-operation.
  assign is_mul  = (alu_func == 6'd1) || (alu_func == 6'd2);
  assign capture = (state == WAIT) && (wait_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      op_ready  <= 1'b1;
      alu_ena   <= 1'b0;
      alu_inp1  <= 32'd0;
      alu_inp2  <= 32'd0;
      alu_shAmt <= 5'd0;
      alu_func  <= 6'd0;
      res_valid <= 1'b0;
      res1_q    <= 32'd0;
      res2_q    <= 32'd0;
      flags_q   <= 4'd0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            if (op_func <= 6'd11) begin
              alu_inp1  <= op_a;
              alu_inp2  <= op_b;
              alu_shAmt <= op_shamt;
              alu_func  <= op_func;
              state     <= SETUP;
            end else begin
              // Illegal func: report without touching the ALU.
              res_err   <= 1'b1;
              res1_q    <= 32'd0;
              res2_q    <= 32'd0;
              flags_q   <= 4'd0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SETUP: begin
          alu_ena <= 1'b1;
          state   <= FIRE;
        end
        FIRE: begin
          alu_ena  <= 1'b0;
          wait_cnt <= is_mul ? MUL_LOAD : ALU_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (capture) begin
            res1_q    <= alu_res1;
            res2_q    <= alu_res2;
            flags_q   <= {alu_carry, alu_sign, alu_ovf, alu_zero};
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  // Clear takes priority over a coincident capture.
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky_q <= 2'b00;
    end else if (capture) begin
      sticky_q <= sticky_q | {alu_carry, alu_ovf};
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU answers each alu_ena rising edge,
// expected results are queued at accept and compared when the result handshake completes.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [5:0]  op_func = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  op_shamt = '0;
  logic [31:0] alu_inp1, alu_inp2;
  logic [4:0]  alu_shAmt;
  logic [5:0]  alu_func;
  logic        alu_ena;
  logic [31:0] alu_res1 = '0;
  logic [31:0] alu_res2 = '0;
  logic        alu_carry = 1'b0, alu_sign = 1'b0, alu_ovf = 1'b0, alu_zero = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res1_q, res2_q;
  logic [3:0]  flags_q;
  logic        res_err;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic        sticky_clr = 1'b0;
  logic [1:0]  sticky_q;
`endif

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  fl;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ena_rises = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_WAIT(1), .MUL_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_func(op_func),
    .op_a(op_a), .op_b(op_b), .op_shamt(op_shamt),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_shAmt(alu_shAmt),
    .alu_func(alu_func), .alu_ena(alu_ena),
    .alu_res1(alu_res1), .alu_res2(alu_res2),
    .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res1_q(res1_q), .res2_q(res2_q), .flags_q(flags_q), .res_err(res_err)
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_q(sticky_q)
`endif
  );

  // Reference ALU: {res1, res2, carry, sign, ovf, zero}
  function automatic logic [67:0] alu_ref(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] r1, r2;
    logic        c, v;
    r1 = '0; r2 = '0; c = 1'b0; v = 1'b0;
    case (f)
      6'd0: begin
        s = {1'b0, a} + {1'b0, b}; r1 = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r1[31] != a[31]);
      end
      6'd1: begin p = {32'd0, a} * {32'd0, b}; r1 = p[63:32]; r2 = p[31:0]; end
      6'd2: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r1 = p[63:32]; r2 = p[31:0]; end
      6'd3: begin
        s = {1'b0, a} - {1'b0, b}; r1 = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r1[31] != a[31]);
      end
      6'd4:  r1 = a & b;
      6'd5:  r1 = a | b;
      6'd6:  r1 = a ^ b;
      6'd7:  r1 = a << sh;
      6'd8:  r1 = a >> sh;
      6'd9:  r1 = a << b[4:0];
      6'd10: r1 = $signed(a) >>> sh;
      6'd11: r1 = a >> b[4:0];
      default: r1 = '0;
    endcase
    return {r1, r2, c, r1[31], v, (r1 == 32'd0)};
  endfunction

  function automatic exp_t mk_exp(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    logic [67:0] r;
    r = alu_ref(f, a, b, sh);
    e.r1 = r[67:36]; e.r2 = r[35:4]; e.fl = r[3:0]; e.err = 1'b0;
    return e;
  endfunction

  // Behavioural ALU evaluates from the DUT's own drive lines on each enable edge.
  always @(posedge alu_ena) begin
    logic [67:0] r;
    r = alu_ref(alu_func, alu_inp1, alu_inp2, alu_shAmt);
    ena_rises = ena_rises + 1;
    {alu_res1, alu_res2, alu_carry, alu_sign, alu_ovf, alu_zero} = r;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_op_ready"}, op_ready, 1);
    check({tag, "_alu_ena"}, alu_ena, 0);
    check({tag, "_alu_inp1"}, alu_inp1, 0);
    check({tag, "_alu_inp2"}, alu_inp2, 0);
    check({tag, "_alu_shamt"}, alu_shAmt, 0);
    check({tag, "_alu_func"}, alu_func, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res1_q"}, res1_q, 0);
    check({tag, "_res2_q"}, res2_q, 0);
    check({tag, "_flags_q"}, flags_q, 0);
    check({tag, "_res_err"}, res_err, 0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input exp_t e,
                        input int lat, input int hold);
    int   cyc, first_v, ena_cyc, ena_cnt, rises0;
    bit   ready_low, stable_ok, legal;
    logic [31:0] held_r1;
    exp_t got_e;
    legal = (f <= 6'd11);
    @(negedge clk);
    op_valid = 1'b1; op_func = f; op_a = a; op_b = b; op_shamt = sh;
    cyc = 0;
    while (!op_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_accept"}, op_ready, 1);
    sb.push_back(e);
    rises0 = ena_rises; first_v = -1; ena_cyc = -1; ena_cnt = 0; ready_low = 1'b1;
    for (int c = 1; c <= 40 && first_v < 0; c++) begin
      @(negedge clk);
      op_valid = 1'b0;
      if (alu_ena) begin
        ena_cnt++;
        if (ena_cyc < 0) ena_cyc = c;
      end
      if (op_ready) ready_low = 1'b0;
      if (res_valid) first_v = c;
    end
    check({tag, "_latency"}, first_v, lat);
    check({tag, "_ena_cycle"}, ena_cyc, legal ? 2 : -1);
    check({tag, "_ena_width"}, ena_cnt, legal ? 1 : 0);
    check({tag, "_ena_edges"}, ena_rises - rises0, legal ? 1 : 0);
    check({tag, "_busy_not_ready"}, ready_low, 1);
    // Consumer stalls while a competing request is presented.
    held_r1 = res1_q;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'b1; op_func = 6'd0; op_a = 32'd1; op_b = 32'd1;
      @(negedge clk);
      if (!res_valid || op_ready || res1_q !== held_r1) stable_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_stall_hold"}, stable_ok, 1);
    op_valid = 1'b0;
    res_ready = 1'b1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      got_e = sb.pop_front();
      check({tag, "_res1"}, res1_q, got_e.r1);
      check({tag, "_res2"}, res2_q, got_e.r2);
      check({tag, "_flags"}, flags_q, got_e.fl);
      check({tag, "_err"}, res_err, got_e.err);
    end
    if (legal) begin
      check({tag, "_inp1_held"}, alu_inp1, a);
      check({tag, "_inp2_held"}, alu_inp2, b);
    end
    $display("op %s func=%0d a=%h b=%h sh=%0d -> res1=%h res2=%h flags=%b err=%b lat=%0d",
             tag, f, a, b, sh, res1_q, res2_q, flags_q, res_err, first_v);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_ready_back"}, op_ready, 1);
  endtask

  exp_t ex;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    check("reset_sticky", sticky_q, 0);
`endif
    rst = 1'b0;

    ex = '{r1: 32'h8000_0000, r2: 32'd0, fl: 4'b0110, err: 1'b0};
    run_op("add_ovf", 6'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, ex, 4, 0);

    ex = '{r1: 32'h0000_0001, r2: 32'hFFFF_FFFE, fl: 4'b0000, err: 1'b0};
    run_op("mulu", 6'd1, 32'hFFFF_FFFF, 32'd2, 5'd0, ex, 7, 0);

    ex = '{r1: 32'd0, r2: 32'd0, fl: 4'b0000, err: 1'b1};
    run_op("illegal", 6'd20, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, ex, 1, 0);

    ex = '{r1: 32'hF800_0000, r2: 32'd0, fl: 4'b0100, err: 1'b0};
    run_op("sra_stall", 6'd10, 32'h8000_0000, 32'd0, 5'd4, ex, 4, 10);

    // Reset in the middle of a multiply's wait phase.
    begin
      int rises0;
      @(negedge clk);
      op_valid = 1'b1; op_func = 6'd1; op_a = 32'd7; op_b = 32'd9; op_shamt = 5'd0;
      repeat (4) begin
        @(negedge clk);
        op_valid = 1'b0;
      end
      rises0 = ena_rises;
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst_no_edge", ena_rises - rises0, 0);
      check("midrst_no_valid", res_valid, 0);
      $display("op midrst func=1 a=7 b=9 -> discarded by reset");
    end

    ex = '{r1: 32'd5, r2: 32'd0, fl: 4'b0000, err: 1'b0};
    run_op("add_after_rst", 6'd0, 32'd2, 32'd3, 5'd0, ex, 4, 0);

    for (int i = 0; i < 8; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      logic [4:0]  sh;
      f  = 6'($urandom_range(0, 11));
      a  = $urandom;
      b  = $urandom;
      sh = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", i), f, a, b, sh, mk_exp(f, a, b, sh),
             (f == 6'd1 || f == 6'd2) ? 7 : 4, i % 3);
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    ex = '{r1: 32'd0, r2: 32'd0, fl: 4'b1001, err: 1'b0};
    run_op("stk_carry", 6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, ex, 4, 0);
    ex = '{r1: 32'd2, r2: 32'd0, fl: 4'b0000, err: 1'b0};
    run_op("stk_plain", 6'd0, 32'd1, 32'd1, 5'd0, ex, 4, 0);
    check("sticky_accum", sticky_q, 2'b10);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("sticky_clear", sticky_q, 2'b00);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
